// File: rtl/keccak_round_scheduler.sv
// Keccak-f round/step sequencer: one step controller owns state memory at a time.
// Optional per-step watchdog built when SCHED_WATCHDOG_EN is defined.
module keccak_round_scheduler #(
  parameter int NUM_ROUNDS  = 24,
  parameter int NUM_STEPS   = 5,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] stepReady,
  output logic                 ready,
  output logic                 done,
  output logic [NUM_STEPS-1:0] stepStart,
  output logic [2:0]           memSel,
  output logic [4:0]           roundIdx,
  output logic                 err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WACK  = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [4:0] round_q, round_d;
  logic       sel_rdy;
  logic       in_wait;

  assign sel_rdy = stepReady[step_q];
  assign in_wait = (state_q == S_WACK) || (state_q == S_WDONE);

`ifdef SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d  = '0;
          round_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WACK;
      S_WACK: begin
        if (!sel_rdy) state_d = S_WDONE;
      end
      S_WDONE: begin
        if (sel_rdy) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (step_q != LAST_STEP) begin
          step_d  = step_q + 3'd1;
          state_d = S_ISSUE;
        end else if (round_q != LAST_ROUND) begin
          step_d  = '0;
          round_d = round_q + 5'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SCHED_WATCHDOG_EN
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (state_q == S_ISSUE) wdog_d = '0;
    // A stuck controller aborts the run; no done pulse is produced.
    if (in_wait) begin
      if (wdog_q == WDOG_LAST) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    stepStart = '0;
    if (state_q == S_ISSUE) stepStart[step_q] = 1'b1;
  end

  // Step 0 (load/output path) owns memory whenever no step is in flight.
  assign memSel   = (state_q == S_IDLE || state_q == S_DONE) ? 3'd0 : step_q;
  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign roundIdx = round_q;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Directed bench for keccak_round_scheduler with ideal step-controller models.
module tb_keccak_round_scheduler;

  localparam int NR = 24;
  localparam int NS = 5;
  localparam int FULL_CYC = 1 + NR * NS * 4 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NS-1:0] stepReady;
  logic          ready, done, err;
  logic [NS-1:0] stepStart;
  logic [2:0]    memSel;
  logic [4:0]    roundIdx;

  logic [NS-1:0] rdy_m;
  logic [NS-1:0] stray_clr = '0;
  int            lat [NS];
  bit            hang [NS];
  int            cnt [NS];

  int  n_chk = 0;
  int  n_pass = 0;
  bit  mon_clr = 1'b0;
  int  exp_s, exp_r, n_starts, n_done;

  keccak_round_scheduler #(
    .NUM_ROUNDS(NR), .NUM_STEPS(NS), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stepReady(stepReady),
    .ready(ready), .done(done), .stepStart(stepStart),
    .memSel(memSel), .roundIdx(roundIdx), .err(err)
  );

  always #5 clk = ~clk;

  assign stepReady = rdy_m & ~stray_clr;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        rdy_m[i] <= 1'b1;
        cnt[i]   <= 0;
      end else if (stepStart[i]) begin
        rdy_m[i] <= 1'b0;
        cnt[i]   <= lat[i] - 1;
      end else if (!rdy_m[i] && !hang[i]) begin
        if (cnt[i] == 0) rdy_m[i] <= 1'b1;
        else cnt[i] <= cnt[i] - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  initial begin
    exp_s = 0; exp_r = 0; n_starts = 0; n_done = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        exp_s = 0; exp_r = 0; n_starts = 0; n_done = 0;
      end else begin
        if (stepStart != '0) begin
          check("start_onehot", 32'(stepStart), 32'(NS'(1) << exp_s));
          check("start_round", 32'(roundIdx), 32'(exp_r));
          check("start_memsel", 32'(memSel), 32'(exp_s));
          n_starts++;
          if (exp_s == NS - 1) begin
            exp_s = 0;
            exp_r++;
          end else exp_s++;
        end
        if (done) n_done++;
      end
    end
  end

  task automatic mon_clear();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_perm(input string tg, input bit hold, input bit stray);
    int cyc;
    mon_clear();
    start = 1'b1;
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      if (stray) stray_clr = NS'($urandom) & ~(NS'(1) << memSel);
    end while (!done && cyc < 3000);
    stray_clr = '0;
    start = 1'b0;
    check({tg, "_done_cyc"}, 32'(cyc), 32'(FULL_CYC));
    @(negedge clk);
    check({tg, "_starts"}, 32'(n_starts), 32'(NR * NS));
    check({tg, "_ready"}, 32'(ready), 32'd1);
    check({tg, "_round_hold"}, 32'(roundIdx), 32'(NR - 1));
    check({tg, "_memsel_idle"}, 32'(memSel), 32'd0);
    repeat (5) @(negedge clk);
    check({tg, "_one_done"}, 32'(n_done), 32'd1);
    check({tg, "_still_idle"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int bad, k;
    for (int i = 0; i < NS; i++) begin
      lat[i]  = 1;
      hang[i] = 1'b0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_start", 32'(stepStart), 32'd0);
    check("rst_memsel", 32'(memSel), 32'd0);
    check("rst_round", 32'(roundIdx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ready || done || stepStart != '0 || memSel != 3'd0) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    run_perm("full", 1'b0, 1'b0);

    lat[1] = 100;
    mon_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!stepStart[1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("var_found", 32'(stepStart[1]), 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (memSel != 3'd1 || stepStart != '0) bad++;
    end
    check("var_busy_hold", 32'(bad), 32'd0);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("var_done", 32'(n_done), 32'd1);
    check("var_starts", 32'(n_starts), 32'(NR * NS));
    lat[1] = 1;

    run_perm("busy", 1'b1, 1'b1);

    mon_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(roundIdx == 5'd7 && memSel == 3'd3) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("mid_found", 32'(roundIdx == 5'd7 && memSel == 3'd3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_ready", 32'(ready), 32'd1);
    check("mid_round", 32'(roundIdx), 32'd0);
    check("mid_memsel", 32'(memSel), 32'd0);
    check("mid_start", 32'(stepStart), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    run_perm("post_rst", 1'b0, 1'b0);

`ifdef SCHED_WATCHDOG_EN
    hang[2] = 1'b1;
    mon_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!stepStart[2] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wd_found", 32'(stepStart[2]), 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err && k < 100);
    check("wd_delay", 32'(k), 32'd17);
    check("wd_err", 32'(err), 32'd1);
    check("wd_idle", 32'(ready), 32'd1);
    check("wd_no_done", 32'(n_done), 32'd0);
    hang[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("wd_sticky", 32'(err), 32'd1);
    mon_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wd_clear", 32'(err), 32'd0);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("wd_rerun_done", 32'(n_done), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
